// File: rtl/gnrc_mfifo_pkg.sv
// ============================================================================
// gnrc_mfifo_pkg : shared types and helpers for the multi-channel memory FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

package gnrc_mfifo_pkg;

   // Tag channel field is sized for the largest supported channel count
   localparam int unsigned MFIFO_CHW_MAX = 8;

   typedef struct packed {
      logic                     vld;
      logic [MFIFO_CHW_MAX-1:0] ch;
   } mfifo_tag_t;

   function automatic int unsigned ch_slice(input int unsigned k, input int unsigned cw);
      return k * cw;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gnrc_mfifo_tag_pipe.sv
// ============================================================================
// gnrc_mfifo_tag_pipe : DELAY-deep read tag pipe with per-channel squash
// Revision: 1.0
// ============================================================================
`default_nettype none

module gnrc_mfifo_tag_pipe
   import gnrc_mfifo_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CHW   = 2,
   parameter int unsigned DELAY = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  mfifo_tag_t       tag_i,
   input  logic [NCH-1:0]   squash_i,
   output logic             vld_o,
   output logic [CHW-1:0]   ch_o
);

   mfifo_tag_t stage_q [DELAY];
   mfifo_tag_t stage_d [DELAY];

   function automatic mfifo_tag_t kill(input mfifo_tag_t t, input logic [NCH-1:0] sq);
      mfifo_tag_t r;
      r = t;
      for (int k = 0; k < NCH; k++) begin
         if (sq[k] && (t.ch == MFIFO_CHW_MAX'(k))) r.vld = 1'b0;
      end
      return r;
   endfunction

   always_comb begin
      stage_d[0] = kill(tag_i, squash_i);
      for (int i = 1; i < DELAY; i++) begin
         stage_d[i] = kill(stage_q[i-1], squash_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DELAY; i++) stage_q[i] <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   // A flush in the cycle a tag reaches the output still suppresses it
   assign vld_o = kill(stage_q[DELAY-1], squash_i).vld;
   assign ch_o  = stage_q[DELAY-1].ch[CHW-1:0];

endmodule

`default_nettype wire

// File: rtl/gnrc_mem2mfifo.sv
// ============================================================================
// gnrc_mem2mfifo : NCH logical FIFOs sharing one external 1W/1R RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module gnrc_mem2mfifo
   import gnrc_mfifo_pkg::*;
#(
   parameter  int unsigned DW    = 32,
   parameter  int unsigned NCH   = 4,
   parameter  int unsigned DP_CH = 16,
   parameter  int unsigned DELAY = 1,
   parameter  int unsigned AFULL = 12,
   localparam int unsigned CHW   = $clog2(NCH),
   localparam int unsigned PW    = $clog2(DP_CH),
   localparam int unsigned AW    = CHW + PW,
   localparam int unsigned CW    = $clog2(DP_CH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NCH-1:0]    flush_i,
   input  logic              wen_i,
   input  logic [CHW-1:0]    wch_i,
   input  logic [DW-1:0]     wdata_i,
   output logic              wack_o,
   input  logic              ren_i,
   input  logic [CHW-1:0]    rch_i,
   output logic              rack_o,
   output logic              rvalid_o,
   output logic [CHW-1:0]    rch_o,
   output logic [DW-1:0]     rdata_o,
   output logic [NCH-1:0]    full_o,
   output logic [NCH-1:0]    empty_o,
   output logic [NCH-1:0]    afull_o,
   output logic [NCH*CW-1:0] cnt_o,
   output logic              mem_wen_o,
   output logic [AW-1:0]     mem_waddr_o,
   output logic [DW-1:0]     mem_wdata_o,
   output logic              mem_ren_o,
   output logic [AW-1:0]     mem_raddr_o,
   input  logic [DW-1:0]     mem_rdata_i
);

   localparam int unsigned NPAD = 2 ** CHW;

   // Channel indices past NCH look permanently full and empty
   logic [NPAD-1:0] full_pad, empty_pad, flush_pad;
   logic [PW-1:0]   wptr_pad [NPAD];
   logic [PW-1:0]   rptr_pad [NPAD];
   mfifo_tag_t      tag_in;

   assign wack_o      = wen_i & ~full_pad[wch_i] & ~flush_pad[wch_i];
   assign rack_o      = ren_i & ~empty_pad[rch_i] & ~flush_pad[rch_i];
   assign mem_wen_o   = wack_o;
   assign mem_ren_o   = rack_o;
   assign mem_waddr_o = {wch_i, wptr_pad[wch_i]};
   assign mem_raddr_o = {rch_i, rptr_pad[rch_i]};
   assign mem_wdata_o = wdata_i;
   assign rdata_o     = mem_rdata_i;

   for (genvar k = 0; k < NPAD; k++) begin : g_pad
      if (k < NCH) begin : g_ch
         localparam int unsigned LSB = ch_slice(k, CW);

         logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
         logic [CW-1:0] cnt_q, cnt_d;
         logic          push, pop;

         assign push = wack_o & (wch_i == CHW'(k));
         assign pop  = rack_o & (rch_i == CHW'(k));

         always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (flush_i[k]) begin
               wptr_d = '0;
               rptr_d = '0;
               cnt_d  = '0;
            end else begin
               if (push) wptr_d = wptr_q + PW'(1);
               if (pop)  rptr_d = rptr_q + PW'(1);
               case ({push, pop})
                  2'b10:   cnt_d = cnt_q + CW'(1);
                  2'b01:   cnt_d = cnt_q - CW'(1);
                  default: cnt_d = cnt_q;
               endcase
            end
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               wptr_q <= '0;
               rptr_q <= '0;
               cnt_q  <= '0;
            end else begin
               wptr_q <= wptr_d;
               rptr_q <= rptr_d;
               cnt_q  <= cnt_d;
            end
         end

         assign full_o[k]          = (cnt_q == CW'(DP_CH));
         assign empty_o[k]         = (cnt_q == '0);
         assign afull_o[k]         = (cnt_q >= CW'(AFULL));
         assign cnt_o[LSB +: CW]   = cnt_q;
         assign full_pad[k]        = full_o[k];
         assign empty_pad[k]       = empty_o[k];
         assign flush_pad[k]       = flush_i[k];
         assign wptr_pad[k]        = wptr_q;
         assign rptr_pad[k]        = rptr_q;
      end else begin : g_none
         assign full_pad[k]  = 1'b1;
         assign empty_pad[k] = 1'b1;
         assign flush_pad[k] = 1'b0;
         assign wptr_pad[k]  = '0;
         assign rptr_pad[k]  = '0;
      end
   end

   assign tag_in.vld = rack_o;
   assign tag_in.ch  = MFIFO_CHW_MAX'(rch_i);

   gnrc_mfifo_tag_pipe #(
      .NCH   (NCH),
      .CHW   (CHW),
      .DELAY (DELAY)
   ) u_tag_pipe (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .tag_i    (tag_in),
      .squash_i (flush_i),
      .vld_o    (rvalid_o),
      .ch_o     (rch_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_gnrc_mem2mfifo.sv
// ============================================================================
// tb_gnrc_mem2mfifo : directed bench for gnrc_mem2mfifo with a 2-cycle RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gnrc_mem2mfifo;

   localparam int DW = 32, NCH = 4, DP_CH = 8, DELAY = 2, AFULL = 6;
   localparam int CHW = 2, AW = 5, CW = 4;

   logic             clk, rst_n;
   logic [NCH-1:0]   flush;
   logic             wen, ren, wack, rack, rvalid;
   logic [CHW-1:0]   wch, rch, rch_o;
   logic [DW-1:0]    wdata, rdata, mem_wdata, mem_rdata;
   logic [NCH-1:0]   full, empty, afull;
   logic [NCH*CW-1:0] cnt;
   logic             mem_wen, mem_ren;
   logic [AW-1:0]    mem_waddr, mem_raddr;

   // Second build with NCH=3 to exercise an out-of-range channel index
   logic [2:0]       flush3, full3, empty3, afull3;
   logic             wen3, ren3, wack3, rack3, rvalid3, mem_wen3, mem_ren3;
   logic [1:0]       wch3, rch3, rch_o3;
   logic [DW-1:0]    wdata3, rdata3, mem_wdata3, mem_rdata3;
   logic [11:0]      cnt3;
   logic [4:0]       mem_waddr3, mem_raddr3;

   int n_tot = 0;
   int n_pass = 0;

   gnrc_mem2mfifo #(.DW(DW), .NCH(NCH), .DP_CH(DP_CH), .DELAY(DELAY), .AFULL(AFULL)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .wen_i(wen), .wch_i(wch), .wdata_i(wdata), .wack_o(wack),
      .ren_i(ren), .rch_i(rch), .rack_o(rack),
      .rvalid_o(rvalid), .rch_o(rch_o), .rdata_o(rdata),
      .full_o(full), .empty_o(empty), .afull_o(afull), .cnt_o(cnt),
      .mem_wen_o(mem_wen), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
      .mem_ren_o(mem_ren), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata)
   );

   gnrc_mem2mfifo #(.DW(DW), .NCH(3), .DP_CH(DP_CH), .DELAY(DELAY), .AFULL(AFULL)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush3),
      .wen_i(wen3), .wch_i(wch3), .wdata_i(wdata3), .wack_o(wack3),
      .ren_i(ren3), .rch_i(rch3), .rack_o(rack3),
      .rvalid_o(rvalid3), .rch_o(rch_o3), .rdata_o(rdata3),
      .full_o(full3), .empty_o(empty3), .afull_o(afull3), .cnt_o(cnt3),
      .mem_wen_o(mem_wen3), .mem_waddr_o(mem_waddr3), .mem_wdata_o(mem_wdata3),
      .mem_ren_o(mem_ren3), .mem_raddr_o(mem_raddr3), .mem_rdata_i(mem_rdata3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-cycle registered RAM
   logic [DW-1:0] mem [32];
   logic [DW-1:0] rd1, rd2;
   always @(posedge clk) begin
      if (mem_wen) mem[mem_waddr] <= mem_wdata;
      if (mem_ren) rd1 <= mem[mem_raddr];
      rd2 <= rd1;
   end
   assign mem_rdata  = rd2;
   assign mem_rdata3 = '0;

   logic [CHW-1:0] q_ch [$];
   logic [DW-1:0]  q_dat [$];
   always @(negedge clk) begin
      if (rst_n && rvalid) begin
         q_ch.push_back(rch_o);
         q_dat.push_back(rdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] cnt_of(input int k);
      return 32'(cnt[k*CW +: CW]);
   endfunction

   function automatic logic [31:0] q_dat0();
      return (q_dat.size() > 0) ? q_dat[0] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] q_ch0();
      return (q_ch.size() > 0) ? 32'(q_ch[0]) : 32'hDEAD_BEEF;
   endfunction

   initial begin
      int bad;
      rst_n = 1'b0; flush = '0; wen = 1'b0; ren = 1'b0; wch = '0; rch = '0; wdata = '0;
      flush3 = '0; wen3 = 1'b0; ren3 = 1'b0; wch3 = '0; rch3 = '0; wdata3 = '0;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();

      chk("rst_empty", 32'(empty), 32'hF);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_afull", 32'(afull), 32'h0);
      chk("rst_cnt", 32'(cnt), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);

      // Fill channel 2
      for (int i = 0; i < 8; i++) begin
         wen = 1'b1; wch = 2'd2; wdata = 32'hA0 + 32'(i);
         #1;
         if (i == 0) chk("waddr_first", 32'(mem_waddr), 32'h10);
         chk("push_ack", 32'(wack), 32'h1);
         cyc();
         if (i == 4) chk("afull_at5", 32'(afull[2]), 32'h0);
         if (i == 5) chk("afull_at6", 32'(afull[2]), 32'h1);
      end
      chk("full_vec", 32'(full), 32'h4);
      chk("cnt2_full", cnt_of(2), 32'd8);
      wdata = 32'hA8;
      #1;
      chk("push_full_ack", 32'(wack), 32'h0);
      chk("push_full_mwen", 32'(mem_wen), 32'h0);
      cyc();
      wen = 1'b0;
      chk("cnt2_after_drop", cnt_of(2), 32'd8);

      // Drain channel 2 back-to-back
      q_ch.delete(); q_dat.delete();
      for (int i = 0; i < 8; i++) begin
         ren = 1'b1; rch = 2'd2;
         #1;
         if (i == 0) begin
            chk("raddr_first", 32'(mem_raddr), 32'h10);
            chk("pop_ack", 32'(rack), 32'h1);
         end
         cyc();
         if (i == 0) chk("rvalid_lat1", 32'(rvalid), 32'h0);
         if (i >= 1) chk("rvalid_b2b", 32'(rvalid), 32'h1);
         if (i == 1) begin
            chk("rch_first", 32'(rch_o), 32'h2);
            chk("rdata_first", rdata, 32'hA0);
         end
      end
      ren = 1'b0;
      repeat (3) cyc();
      chk("pop_count", 32'(q_dat.size()), 32'd8);
      bad = 0;
      for (int j = 0; j < q_dat.size(); j++) begin
         if (q_dat[j] !== 32'hA0 + 32'(j) || q_ch[j] !== 2'd2) bad++;
      end
      chk("pop_order", 32'(bad), 32'd0);
      chk("cnt2_drained", cnt_of(2), 32'd0);

      // Push ch0 while popping ch3 in the same cycle
      for (int i = 0; i < 3; i++) begin
         wen = 1'b1; wch = 2'd3; wdata = 32'h31 + 32'(i);
         cyc();
      end
      q_ch.delete(); q_dat.delete();
      wch = 2'd0; wdata = 32'h11; ren = 1'b1; rch = 2'd3;
      #1;
      chk("inter_acks", {30'd0, wack, rack}, 32'h3);
      cyc();
      wen = 1'b0; ren = 1'b0;
      chk("inter_cnt0", cnt_of(0), 32'd1);
      chk("inter_cnt3", cnt_of(3), 32'd2);
      repeat (3) cyc();
      chk("inter_ret_n", 32'(q_dat.size()), 32'd1);
      chk("inter_ret_data", q_dat0(), 32'h31);
      chk("inter_ret_ch", q_ch0(), 32'h3);

      // Same-channel push+pop with pointer wrap on ch1
      for (int i = 0; i < 4; i++) begin
         wen = 1'b1; wch = 2'd1; wdata = 32'h40 + 32'(i);
         cyc();
      end
      chk("cnt1_pre", cnt_of(1), 32'd4);
      q_ch.delete(); q_dat.delete();
      for (int i = 0; i < 20; i++) begin
         wen = 1'b1; wch = 2'd1; wdata = 32'h50 + 32'(i); ren = 1'b1; rch = 2'd1;
         #1;
         if (i == 0) chk("same_acks", {30'd0, wack, rack}, 32'h3);
         cyc();
         if (i == 0) chk("same_cnt_first", cnt_of(1), 32'd4);
      end
      wen = 1'b0; ren = 1'b0;
      chk("same_cnt_end", cnt_of(1), 32'd4);
      repeat (3) cyc();
      chk("wrap_count", 32'(q_dat.size()), 32'd20);
      bad = 0;
      for (int j = 0; j < q_dat.size(); j++) begin
         if (q_dat[j] !== ((j < 4) ? 32'h40 + 32'(j) : 32'h50 + 32'(j - 4)) || q_ch[j] !== 2'd1) bad++;
      end
      chk("wrap_order", 32'(bad), 32'd0);

      // Flush ch1 right after two ch1 pops; ch0 pop in the flush cycle survives
      q_ch.delete(); q_dat.delete();
      ren = 1'b1; rch = 2'd1;
      cyc();
      cyc();
      rch = 2'd0; flush = 4'b0010; wen = 1'b1; wch = 2'd1; wdata = 32'hEE;
      #1;
      chk("flush_rvalid_sq", 32'(rvalid), 32'h0);
      chk("flush_push_rej", 32'(wack), 32'h0);
      chk("flush_pop_ch0", 32'(rack), 32'h1);
      cyc();
      flush = '0; wen = 1'b0; ren = 1'b0;
      chk("flush_cnt1", cnt_of(1), 32'd0);
      chk("flush_empty1", 32'(empty[1]), 32'h1);
      chk("flush_cnt3", cnt_of(3), 32'd2);
      repeat (3) cyc();
      chk("flush_ret_n", 32'(q_dat.size()), 32'd1);
      chk("flush_ret_ch", q_ch0(), 32'h0);
      chk("flush_ret_data", q_dat0(), 32'h11);

      // Pop from empty ch0
      ren = 1'b1; rch = 2'd0;
      #1;
      chk("empty_pop_ack", 32'(rack), 32'h0);
      chk("empty_pop_mren", 32'(mem_ren), 32'h0);
      ren = 1'b0;

      // Out-of-range channel on the NCH=3 build
      wen3 = 1'b1; wch3 = 2'd3; wdata3 = 32'h99; ren3 = 1'b1; rch3 = 2'd3;
      #1;
      chk("oor_wack", 32'(wack3), 32'h0);
      chk("oor_mwen", 32'(mem_wen3), 32'h0);
      chk("oor_rack", 32'(rack3), 32'h0);
      chk("oor_mren", 32'(mem_ren3), 32'h0);
      ren3 = 1'b0; wch3 = 2'd2;
      #1;
      chk("n3_valid_wack", 32'(wack3), 32'h1);
      cyc();
      wen3 = 1'b0;
      chk("n3_cnt", 32'(cnt3), 32'h100);

      // Reset in the middle of a pending return
      wen = 1'b1; wch = 2'd0; wdata = 32'h77;
      cyc();
      wen = 1'b0; ren = 1'b1; rch = 2'd0;
      q_ch.delete(); q_dat.delete();
      cyc();
      ren = 1'b0; rst_n = 1'b0;
      #1;
      chk("mid_rst_cnt", 32'(cnt), 32'h0);
      chk("mid_rst_empty", 32'(empty), 32'hF);
      chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
      cyc();
      rst_n = 1'b1;
      repeat (3) cyc();
      chk("mid_rst_lost", 32'(q_dat.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

`default_nettype wire
